// File: rtl/demux_pkg.sv
// Shared definitions for the handshaked 1-to-N stream demultiplexer.
// Holds the select-width helper, the channel limit and the delivery-mode encodings.
package demux_pkg;

  localparam int MAX_CH = 16;

  localparam logic MODE_UNICAST = 1'b0;
  localparam logic MODE_BCAST   = 1'b1;

  // Width of a channel select; a 1-channel-wide select still needs one bit.
  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output slot of the stream demultiplexer.
// A word loaded here is visible on the next cycle. It is held until the consumer takes it.
module demux_out_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d,  data_q;

  // A load in the same cycle as a drain keeps valid high, so there is no bubble.
  always_comb begin
    valid_d = load | (valid_q & ~out_ready);
    data_d  = load ? load_data : data_q;
  end

  // NOTE: the data register is reset as well as valid, because out_data must read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/demux_stream_1xn.sv
// Registered 1-to-N stream demultiplexer with unicast and all-or-nothing broadcast.
// Each channel has its own one-entry slot. Words with an out-of-range select are counted and dropped.
module demux_stream_1xn
  import demux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 8,
  parameter  int CNT_W  = 8,
  localparam int SEL_W  = sel_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     sel_err
);

  logic [NUM_CH-1:0] free;
  logic [NUM_CH-1:0] target;
  logic [NUM_CH-1:0] load;
  logic [31:0]       sel_ext;
  logic              sel_in_range;
  logic              accept;
  logic              drop;

  logic [CNT_W-1:0]  drop_cnt_d, drop_cnt_q;
  logic              sel_err_d,  sel_err_q;

  assign free    = ~out_valid | out_ready;
  assign sel_ext = 32'(in_sel);
  assign sel_in_range = (sel_ext < NUM_CH);

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    target = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      target[k] = (in_bcast == MODE_BCAST) || (in_sel == SEL_W'(k));
    end

    // in_ready does not depend on in_valid, so the producer sees it without a combinational loop.
    if (in_bcast == MODE_BCAST) begin
      in_ready = &free;
    end else if (sel_in_range) begin
      in_ready = |(target & free);
    end else begin
      in_ready = 1'b1;
    end

    accept = in_valid & in_ready;
    load   = target & {NUM_CH{accept}};
    drop   = accept & (in_bcast == MODE_UNICAST) & ~sel_in_range;

    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
    sel_err_d = sel_err_q | drop;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
      sel_err_q  <= 1'b0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      sel_err_q  <= sel_err_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign sel_err  = sel_err_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_out_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[k]),
      .load_data (in_data),
      .out_ready (out_ready[k]),
      .out_valid (out_valid[k]),
      .out_data  (out_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_demux_stream_1xn.sv
// Directed bench for demux_stream_1xn: a 4-channel build for routing and back-pressure,
// and a 3-channel build for out-of-range drops and counter saturation.
module tb_demux_stream_1xn;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic        a_in_valid, a_in_ready, a_in_bcast, a_sel_err;
  logic [7:0]  a_in_data, a_drop_cnt;
  logic [1:0]  a_in_sel;
  logic [3:0]  a_out_valid, a_out_ready;
  logic [31:0] a_out_data;

  // 3-channel instance
  logic        b_in_valid, b_in_ready, b_in_bcast, b_sel_err;
  logic [7:0]  b_in_data, b_drop_cnt;
  logic [1:0]  b_in_sel;
  logic [2:0]  b_out_valid, b_out_ready;
  logic [23:0] b_out_data;

  demux_stream_1xn #(.NUM_CH(4), .DATA_W(8), .CNT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_sel(a_in_sel), .in_bcast(a_in_bcast),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .drop_cnt(a_drop_cnt), .sel_err(a_sel_err)
  );

  demux_stream_1xn #(.NUM_CH(3), .DATA_W(8), .CNT_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_sel(b_in_sel), .in_bcast(b_in_bcast),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .drop_cnt(b_drop_cnt), .sel_err(b_sel_err)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
    logic [3:0] exp_valid;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{sel: 2'd0, data: 8'hA0, exp_valid: 4'b0001};
    vecs[1] = '{sel: 2'd1, data: 8'hA1, exp_valid: 4'b0010};
    vecs[2] = '{sel: 2'd2, data: 8'hA2, exp_valid: 4'b0100};
    vecs[3] = '{sel: 2'd3, data: 8'hA3, exp_valid: 4'b1000};

    a_in_valid = 0; a_in_data = 0; a_in_sel = 0; a_in_bcast = 0; a_out_ready = 4'hF;
    b_in_valid = 0; b_in_data = 0; b_in_sel = 0; b_in_bcast = 0; b_out_ready = 3'h7;

    // Reset values
    #1;
    tick(); tick();
    check("rst_out_valid4", 32'(a_out_valid), 32'h0);
    check("rst_out_data4",  a_out_data, 32'h0);
    check("rst_drop_cnt4",  32'(a_drop_cnt), 32'h0);
    check("rst_sel_err3",   32'(b_sel_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Unicast table, all consumers ready
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1; a_in_sel = vecs[i].sel; a_in_data = vecs[i].data;
      #1;
      check($sformatf("uni_in_ready[%0d]", i), 32'(a_in_ready), 32'h1);
      tick();
      check($sformatf("uni_valid[%0d]", i), 32'(a_out_valid), 32'(vecs[i].exp_valid));
      check($sformatf("uni_data[%0d]", i),
            32'(a_out_data[vecs[i].sel*8 +: 8]), 32'(vecs[i].data));
    end
    a_in_valid = 0;
    tick();
    check("uni_drained", 32'(a_out_valid), 32'h0);

    // Back-pressure on ch2
    a_out_ready = 4'b1011;
    a_in_valid = 1; a_in_sel = 2; a_in_data = 8'h11;
    tick();
    check("bp_ch2_loaded", 32'(a_out_data[23:16]), 32'h11);
    a_in_data = 8'h22;
    #1;
    check("bp_in_ready_sel2", 32'(a_in_ready), 32'h0);
    tick();
    check("bp_ch2_held", 32'(a_out_data[23:16]), 32'h11);
    a_in_sel = 1; a_in_data = 8'h33;
    #1;
    check("bp_in_ready_sel1", 32'(a_in_ready), 32'h1);
    tick();
    check("bp_valid_ch1_ch2", 32'(a_out_valid), 32'b0110);
    check("bp_ch1_data", 32'(a_out_data[15:8]), 32'h33);
    // Release: 0x11 leaves on this edge while 0x22 refills the slot
    a_out_ready = 4'hF; a_in_sel = 2; a_in_data = 8'h22;
    #1;
    check("bp_release_ready", 32'(a_in_ready), 32'h1);
    tick();
    check("bp_refill_valid", 32'(a_out_valid), 32'b0100);
    check("bp_refill_data", 32'(a_out_data[23:16]), 32'h22);
    a_in_valid = 0;
    tick();
    check("bp_idle", 32'(a_out_valid), 32'h0);

    // Broadcast with ch2 stalled and occupied
    a_out_ready = 4'b1011;
    a_in_valid = 1; a_in_sel = 2; a_in_data = 8'h44;
    tick();
    a_in_bcast = 1; a_in_sel = 0; a_in_data = 8'h5A;
    #1;
    check("bc_blocked", 32'(a_in_ready), 32'h0);
    tick();
    check("bc_no_partial", 32'(a_out_valid), 32'b0100);
    check("bc_ch2_old", 32'(a_out_data[23:16]), 32'h44);
    a_out_ready = 4'hF;
    #1;
    check("bc_unblocked", 32'(a_in_ready), 32'h1);
    tick();
    check("bc_all_valid", 32'(a_out_valid), 32'hF);
    check("bc_all_data", a_out_data, 32'h5A5A5A5A);
    a_in_valid = 0; a_in_bcast = 0;
    tick();

    // Back-to-back unicast to ch0 at full rate
    a_in_valid = 1; a_in_sel = 0;
    for (int i = 0; i < 5; i++) begin
      a_in_data = 8'h10 + 8'(i);
      #1;
      check($sformatf("b2b_ready[%0d]", i), 32'(a_in_ready), 32'h1);
      tick();
      check($sformatf("b2b_valid[%0d]", i), 32'(a_out_valid), 32'b0001);
      check($sformatf("b2b_data[%0d]", i), 32'(a_out_data[7:0]), 32'(8'h10 + 8'(i)));
    end
    a_in_valid = 0;
    tick();

    // 3-channel build: in-range unicast is routed, sel=3 is dropped
    b_in_valid = 1; b_in_sel = 2; b_in_data = 8'hC2;
    tick();
    check("n3_ch2_valid", 32'(b_out_valid), 32'b100);
    check("n3_ch2_data", 32'(b_out_data[23:16]), 32'hC2);
    check("n3_no_drop", 32'(b_drop_cnt), 32'h0);
    b_in_sel = 3; b_in_data = 8'hFF;
    #1;
    check("drop_in_ready", 32'(b_in_ready), 32'h1);
    tick();
    check("drop_no_valid", 32'(b_out_valid), 32'h0);
    check("drop_cnt_1", 32'(b_drop_cnt), 32'h1);
    check("drop_sel_err", 32'(b_sel_err), 32'h1);
    b_in_valid = 0;
    tick();
    check("drop_err_sticky", 32'(b_sel_err), 32'h1);
    b_in_valid = 1;
    for (int i = 0; i < 299; i++) tick();
    b_in_valid = 0;
    tick();
    check("drop_saturated", 32'(b_drop_cnt), 32'hFF);

    // Asynchronous reset with slots full
    a_out_ready = 4'h0;
    a_in_valid = 1; a_in_sel = 0; a_in_data = 8'hD0;
    tick();
    a_in_sel = 3; a_in_data = 8'hD3;
    tick();
    a_in_valid = 0;
    check("pre_rst_valid", 32'(a_out_valid), 32'b1001);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(a_out_valid), 32'h0);
    check("async_rst_data", a_out_data, 32'h0);
    check("async_rst_drop_cnt", 32'(b_drop_cnt), 32'h0);
    check("async_rst_sel_err", 32'(b_sel_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    a_out_ready = 4'hF;
    tick(); tick();
    check("post_rst_valid", 32'(a_out_valid), 32'h0);
    check("post_rst_data", a_out_data, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
